// File: rtl/remote_cmd_seq_pkg.sv
// Shared types and constants for the RemoteComm command sequencer.
package remote_cmd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NAK     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } seq_err_t;

  localparam logic [15:0] CMD_CAL = 16'h0000;
  localparam logic [7:0]  POS_ACK = 8'hA5;

endpackage

// File: rtl/remote_cmd_fifo.sv
// DEPTH x 16 synchronous command FIFO with flush; head is read straight from the storage flops.
module cmd_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wr_data,
  output logic [15:0]   head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push  = push && !flush && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/remote_cmd_seq.sv
// Queues 16-bit tour commands and issues them one at a time to RemoteComm, checking each acknowledge.
// Define REMOTE_CMD_SEQ_TIMEOUT_EN to build the response timeout counter and its error path.
module remote_cmd_seq
  import remote_cmd_seq_pkg::*;
#(
  parameter  int          DEPTH   = 8,
  parameter  int          TIMEOUT = 4_000_000,
  parameter  logic [7:0]  ACK     = POS_ACK,
  localparam int          CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_cmd,
  input  logic [15:0]   wr_data,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   cmd,
  output logic          snd_cmd,
  input  logic          cmd_snt,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [7:0]    acked
);

  seq_state_t  state_q, state_d;
  seq_err_t    err_code_q, err_code_d;
  logic [15:0] cmd_q, cmd_d;
  logic        snd_cmd_q, snd_cmd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  acked_q, acked_d;

  logic        fifo_pop, fifo_flush, fifo_empty;
  logic [15:0] fifo_head;
  logic        timer_expired;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_cmd),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (wr_data),
    .head    (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .count   (count)
  );

`ifdef REMOTE_CMD_SEQ_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Zeroed on the way into SEND so the count equals cycles elapsed since snd_cmd.
  always_comb begin
    timer_d = timer_q;
    unique case (state_q)
      S_POP:                           timer_d = '0;
      S_SEND, S_WAIT_SNT, S_WAIT_RESP: if (timer_q != TIMER_LAST) timer_d = timer_q + TW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign timer_expired = (timer_q == TIMER_LAST);
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    acked_d    = acked_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) begin
        if (!fifo_empty) begin
          state_d    = S_POP;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          acked_d    = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      S_POP: begin
        fifo_pop = 1'b1;
        cmd_d    = fifo_head;
        state_d  = S_SEND;
      end
      S_SEND:     state_d = S_WAIT_SNT;
      S_WAIT_SNT: if (cmd_snt) state_d = S_WAIT_RESP;
      S_WAIT_RESP: if (resp_rdy) begin
        if (resp == ACK) begin
          if (acked_q != 8'hFF) acked_d = acked_q + 8'd1;
          if (!fifo_empty) begin
            state_d = S_POP;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_NAK;
          fifo_flush = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A response arriving in the expiry cycle takes precedence over the timeout.
    if (timer_expired && (state_q == S_WAIT_SNT || (state_q == S_WAIT_RESP && !resp_rdy))) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      fifo_flush = 1'b1;
      state_d    = S_IDLE;
    end

    // Abort overrides everything and leaves the queue and cmd untouched for a later restart.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      cmd_d      = cmd_q;
      done_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = ERR_ABORT;
      acked_d    = acked_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
    end

    snd_cmd_d = (state_d == S_SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_CAL;
      snd_cmd_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      acked_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      snd_cmd_q  <= snd_cmd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      acked_q    <= acked_d;
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign acked    = acked_q;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Self-checking bench for remote_cmd_seq; the bench itself plays the RemoteComm side of the handshake.
module tb_remote_cmd_seq;

  localparam int         DEPTH = 8;
  localparam int         CW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] ACK_B = 8'hA5;

  logic          clk, rst_n, wr_cmd, full, start, abort, snd_cmd, cmd_snt, resp_rdy;
  logic          busy, done, err;
  logic [15:0]   wr_data, cmd;
  logic [CW-1:0] count;
  logic [7:0]    resp, acked;
  logic [1:0]    err_code;

  int checks, failures;
  logic [15:0] exp_q [$];  // commands expected to be queued, in issue order

  remote_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(100), .ACK(ACK_B)) dut (
    .clk(clk), .rst_n(rst_n), .wr_cmd(wr_cmd), .wr_data(wr_data), .full(full), .count(count),
    .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .acked(acked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [15:0] d);
    wr_cmd = 1'b1; wr_data = d;
    step();
    wr_cmd = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  // Steps until snd_cmd is seen; n = cycles from the negedge where the pulse inputs were raised.
  task automatic wait_snd(output int n);
    n = 0;
    do begin
      step();
      start = 1'b0; resp_rdy = 1'b0; cmd_snt = 1'b0;
      n++;
    end while (snd_cmd !== 1'b1 && n < 200);
  endtask

  // Called in the SEND cycle; returns in WAIT_RESP after d_resp idle cycles.
  task automatic handshake(input int d_snt, input int d_resp);
    repeat (d_snt) step();
    cmd_snt = 1'b1;
    step();
    cmd_snt = 1'b0;
    repeat (d_resp) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    #1;
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    checks++; if ({snd_cmd, busy, done, err} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {snd_cmd, busy, done, err}); end
    checks++; if ({err_code, acked} !== 10'd0) begin failures++; $display("FAIL reset_err_acked: got %h/%h want 0/0", err_code, acked); end
    checks++; if ({count, full} !== '0) begin failures++; $display("FAIL reset_count_full: got %0d/%b want 0/0", count, full); end
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    exp_q.delete();
    push_cmd(16'h0000); push_cmd(16'h2bf1);
    start = 1'b1; wait_snd(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_start_latency: got %0d want 2", lat); end
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL basic_cmd0: got %h want 0000", cmd); end
    handshake(1, 0);
    resp = ACK_B; resp_rdy = 1'b1; wait_snd(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_ack_latency: got %0d want 2", lat); end
    checks++; if (cmd !== 16'h2bf1) begin failures++; $display("FAIL basic_cmd1: got %h want 2bf1", cmd); end
    handshake(2, 1);
    resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
    checks++; if ({done, busy, err} !== 3'b100) begin failures++; $display("FAIL basic_done: got done/busy/err %b want 100", {done, busy, err}); end
    checks++; if (acked !== 8'd2) begin failures++; $display("FAIL basic_acked: got %0d want 2", acked); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    exp_q.delete();
  endtask

  task automatic test_nak();
    int lat;
    exp_q.delete();
    repeat (3) push_cmd(16'($urandom));
    start = 1'b1; wait_snd(lat);
    handshake(1, 2);
    resp = ACK_B; resp_rdy = 1'b1; wait_snd(lat);
    handshake(3, 0);
    resp = 8'h5A; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
    exp_q.delete();
    checks++; if ({busy, err, err_code} !== 4'b0101) begin failures++; $display("FAIL nak_state: got busy/err/code %b want 0101", {busy, err, err_code}); end
    checks++; if (count !== '0) begin failures++; $display("FAIL nak_flush: got count %0d want 0", count); end
    checks++; if (acked !== 8'd1) begin failures++; $display("FAIL nak_acked: got %0d want 1", acked); end
    step();
  endtask

  task automatic test_random_runs();
    int n, nak_at, lat, served;
    logic [15:0] exp_cmd;
    logic [7:0] b;
    bit fin;
    for (int r = 0; r < 8; r++) begin
      exp_q.delete();
      n = $urandom_range(1, DEPTH);
      nak_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      served = 0; fin = 1'b0;
      for (int i = 0; i < n; i++) push_cmd(16'($urandom));
      start = 1'b1; wait_snd(lat);
      while (!fin) begin
        checks++;
        if (lat != 2) begin
          failures++; $display("FAIL rand_latency: run %0d cmd %0d got %0d want 2", r, served, lat);
          rst_n = 1'b0; step(); rst_n = 1'b1; exp_q.delete();
          break;
        end
        exp_cmd = exp_q.pop_front();
        checks++; if (cmd !== exp_cmd) begin failures++; $display("FAIL rand_cmd: run %0d cmd %0d got %h want %h", r, served, cmd, exp_cmd); end
        if (served == 0 && r[0]) push_cmd(16'($urandom));
        handshake(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        if (served == nak_at) begin
          b = 8'($urandom_range(0, 255));
          if (b == ACK_B) b = 8'h5A;
        end else begin
          b = ACK_B;
        end
        resp = b; resp_rdy = 1'b1;
        if (b != ACK_B) begin
          step(); resp_rdy = 1'b0; exp_q.delete(); fin = 1'b1;
          checks++; if ({busy, err, err_code, count} !== {4'b0101, CW'(0)}) begin failures++; $display("FAIL rand_nak: run %0d got busy/err/code %b count %0d want 0101 0", r, {busy, err, err_code}, count); end
          checks++; if (acked !== 8'(served)) begin failures++; $display("FAIL rand_nak_acked: run %0d got %0d want %0d", r, acked, served); end
        end else begin
          served++;
          if (exp_q.size() == 0) begin
            step(); resp_rdy = 1'b0; fin = 1'b1;
            checks++; if ({done, busy, err} !== 3'b100) begin failures++; $display("FAIL rand_done: run %0d got done/busy/err %b want 100", r, {done, busy, err}); end
            checks++; if (acked !== 8'(served)) begin failures++; $display("FAIL rand_acked: run %0d got %0d want %0d", r, acked, served); end
          end else begin
            wait_snd(lat);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_fifo_full();
    int lat, bad;
    logic [15:0] exp_cmd;
    exp_q.delete();
    for (int i = 0; i < 9; i++) push_cmd(16'h1000 + 16'(i));
    checks++; if ({count, full} !== {CW'(8), 1'b1}) begin failures++; $display("FAIL full_drop: got count %0d full %b want 8 1", count, full); end
    start = 1'b1; step(); start = 1'b0;
    wr_cmd = 1'b1; wr_data = 16'hBEEF; step(); wr_cmd = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(16'hBEEF);
    checks++; if ({count, full} !== {CW'(8), 1'b1}) begin failures++; $display("FAIL full_push_pop: got count %0d full %b want 8 1", count, full); end
    checks++; if ({snd_cmd, cmd} !== {1'b1, 16'h1000}) begin failures++; $display("FAIL full_first_send: got snd %b cmd %h want 1 1000", snd_cmd, cmd); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if ({busy, err_code, count} !== {1'b0, 2'b11, CW'(8)}) begin failures++; $display("FAIL full_abort: got busy %b code %b count %0d want 0 11 8", busy, err_code, count); end
    bad = 0;
    start = 1'b1; wait_snd(lat);
    for (int i = 0; i < DEPTH; i++) begin
      exp_cmd = exp_q.pop_front();
      if (lat != 2 || cmd !== exp_cmd) bad++;
      handshake(1, 0);
      resp = ACK_B; resp_rdy = 1'b1;
      if (i < DEPTH - 1) wait_snd(lat);
      else begin step(); resp_rdy = 1'b0; end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_drain_order: got %0d bad commands want 0", bad); end
    checks++; if ({done, acked} !== {1'b1, 8'd8}) begin failures++; $display("FAIL full_drain_done: got done %b acked %0d want 1 8", done, acked); end
    step();
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] first, exp_cmd;
    exp_q.delete();
    repeat (3) push_cmd(16'($urandom));
    start = 1'b1; wait_snd(lat);
    first = exp_q.pop_front();
    handshake(1, 1);
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if ({busy, err, err_code} !== 4'b0111) begin failures++; $display("FAIL abort_state: got busy/err/code %b want 0111", {busy, err, err_code}); end
    checks++; if ({count, cmd} !== {CW'(2), first}) begin failures++; $display("FAIL abort_retain: got count %0d cmd %h want 2 %h", count, cmd, first); end
    start = 1'b1; wait_snd(lat);
    exp_cmd = exp_q.pop_front();
    checks++; if ({err, err_code} !== 3'b000) begin failures++; $display("FAIL abort_restart_clear: got err/code %b want 000", {err, err_code}); end
    checks++; if (lat != 2 || cmd !== exp_cmd) begin failures++; $display("FAIL abort_resume: got lat %0d cmd %h want 2 %h", lat, cmd, exp_cmd); end
    handshake(2, 0);
    resp = ACK_B; resp_rdy = 1'b1; wait_snd(lat);
    exp_cmd = exp_q.pop_front();
    checks++; if (cmd !== exp_cmd) begin failures++; $display("FAIL abort_resume_next: got %h want %h", cmd, exp_cmd); end
    handshake(1, 2);
    resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
    checks++; if ({done, acked} !== {1'b1, 8'd2}) begin failures++; $display("FAIL abort_resume_done: got done %b acked %0d want 1 2", done, acked); end
    step();
  endtask

`ifdef REMOTE_CMD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    exp_q.delete();
    push_cmd(16'h2bf1); push_cmd(16'h0000);
    start = 1'b1; wait_snd(lat);
    step(); cmd_snt = 1'b1; step(); cmd_snt = 1'b0;
    repeat (97) step();
    checks++; if ({busy, err} !== 2'b10) begin failures++; $display("FAIL timeout_early: got busy/err %b at 99 cycles want 10", {busy, err}); end
    step();
    checks++; if ({busy, err, err_code} !== 4'b0110) begin failures++; $display("FAIL timeout_fire: got busy/err/code %b at 100 cycles want 0110", {busy, err, err_code}); end
    checks++; if (count !== '0) begin failures++; $display("FAIL timeout_flush: got count %0d want 0", count); end
    exp_q.delete();
    push_cmd(16'h0000);
    start = 1'b1; wait_snd(lat);
    step(); cmd_snt = 1'b1; step(); cmd_snt = 1'b0;
    repeat (97) step();
    resp = ACK_B; resp_rdy = 1'b1; step(); resp_rdy = 1'b0;
    checks++; if ({done, err, acked} !== {2'b10, 8'd1}) begin failures++; $display("FAIL timeout_resp_wins: got done %b err %b acked %0d want 1 0 1", done, err, acked); end
    exp_q.delete();
    step();
  endtask
`else
  task automatic test_no_timeout();
    int lat;
    exp_q.delete();
    push_cmd(16'h0000);
    start = 1'b1; wait_snd(lat);
    step(); cmd_snt = 1'b1; step(); cmd_snt = 1'b0;
    repeat (10000) step();
    checks++; if ({busy, err} !== 2'b10) begin failures++; $display("FAIL no_timeout_wait: got busy/err %b want 10", {busy, err}); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if ({busy, err_code} !== 3'b011) begin failures++; $display("FAIL no_timeout_abort: got busy/code %b want 011", {busy, err_code}); end
    exp_q.delete();
  endtask
`endif

  task automatic test_empty_start();
    bit seen;
    start = 1'b1; step(); start = 1'b0;
    seen = snd_cmd;
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL empty_done: got done/busy %b want 10", {done, busy}); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_pulse: got %b want 0", done); end
    repeat (5) begin seen |= snd_cmd; step(); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL empty_no_send: got snd_cmd seen %b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_q.delete();
    push_cmd(16'h2bf1); push_cmd(16'h1234);
    start = 1'b1; wait_snd(lat);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL midreset_cmd: got %h want 0000", cmd); end
    checks++; if ({snd_cmd, busy, done, err, err_code, acked} !== 14'd0) begin failures++; $display("FAIL midreset_flags: got %b want 0", {snd_cmd, busy, done, err, err_code, acked}); end
    checks++; if ({count, full} !== '0) begin failures++; $display("FAIL midreset_fifo: got count %0d full %b want 0 0", count, full); end
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle: got busy %b want 0", busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; wr_cmd = 1'b0; wr_data = '0; start = 1'b0; abort = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
    test_reset();
    test_basic();
    test_nak();
    test_random_runs();
    test_fifo_full();
    test_abort();
`ifdef REMOTE_CMD_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_empty_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/remote_cmd_seq.md
# remote_cmd_seq

Host-side command sequencer sitting directly upstream of the RemoteComm UART bridge in the Knight's Tour bench and host stack. It queues 16-bit tour commands (calibrate 0x0000, move 0x2bf1, …), issues them one at a time to RemoteComm's `cmd`/`snd_cmd` port, and waits for transmission completion and the DUT's acknowledge. It then checks the acknowledge byte and advances, aborts or flags an error, replacing hand-written per-command sequencing.

## Interface
- `DEPTH`, 8: command FIFO entries; power of 2, range 2–32.
- `TIMEOUT`, 4_000_000: cycles allowed from `snd_cmd` to `resp_rdy`.
- `ACK`, 8'hA5: positive-acknowledge byte.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `wr_cmd` in 1: push `wr_data` into the FIFO.
- `wr_data` in 16: command word.
- `full` out 1: FIFO full.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `start` in 1: begin draining the FIFO. Ignored unless in IDLE.
- `abort` in 1: stop after the current cycle.
- `cmd` out 16: command to RemoteComm.
- `snd_cmd` out 1: one-cycle send strobe.
- `cmd_snt` in 1: RemoteComm finished transmitting.
- `resp_rdy` in 1: response byte valid (pulse).
- `resp` in 8: response byte.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the FIFO drains with no error.
- `err` out 1: sticky; cleared by the next accepted `start`.
- `err_code` out 2: 00 none, 01 NAK, 10 timeout, 11 abort.
- `acked` out 8: commands acknowledged since the last `start`; saturates at 255.

## Operation
- Reset values: `cmd`=0, `snd_cmd`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00, `acked`=0, `count`=0, `full`=0. The FIFO is emptied.
- States: IDLE, POP, SEND, WAIT_SNT, WAIT_RESP.
- IDLE:
  - `start` with `count`>0 goes to POP and clears `err`, `err_code` and `acked`.
  - `start` with `count`=0 pulses `done` next cycle and stays in IDLE.
- POP: pop the FIFO head into the `cmd` register, then go to SEND.
- SEND: assert `snd_cmd` for exactly one cycle, clear the timeout counter, then go to WAIT_SNT.
- WAIT_SNT: on `cmd_snt`=1, go to WAIT_RESP.
- WAIT_RESP: on `resp_rdy`:
  - `resp`==`ACK`: increment `acked`. Go to POP if `count`>0; otherwise pulse `done` and go to IDLE.
  - Any other value: `err`=1, `err_code`=01, flush the FIFO, go to IDLE.
- `resp_rdy` in WAIT_SNT is ignored. `cmd_snt` and `resp_rdy` in IDLE are ignored.
- FIFO writes:
  - `wr_cmd` while `full` is dropped silently; `count` is unchanged.
  - Push and pop in the same cycle keep `count` constant. This is legal even when full, because the pop frees the slot first.
  - Writes during a run are allowed and are executed in the same run.
- `abort` in any non-IDLE state: go to IDLE next cycle with `err`=1, `err_code`=11. The FIFO is retained and `cmd` holds its last value. `abort` in IDLE has no effect.
- `start` and `abort` together in IDLE: `start` wins.
- Reset mid-operation returns to the reset values immediately. Any in-flight RemoteComm transfer is not tracked.

## Timing
- `start` to `snd_cmd` high: 2 cycles (IDLE→POP→SEND). `snd_cmd` is high in the SEND cycle.
- An ack `resp_rdy` at cycle t with more commands queued gives the next `snd_cmd` at t+2.
- `done` and `err` update on the clock edge after the qualifying `resp_rdy`.
- Timeout counter:
  - Width $clog2(TIMEOUT+1). It counts every cycle in WAIT_SNT and WAIT_RESP.
  - At count == TIMEOUT-1 without `resp_rdy`: `err`=1, `err_code`=10, flush the FIFO, go to IDLE.
  - If `resp_rdy` arrives in that same cycle, the response wins.

## Configuration
- `REMOTE_CMD_SEQ_TIMEOUT_EN` defined: the timeout counter and the timeout error path exist as above.
- Undefined: no counter is synthesized, `err_code`=10 is never produced, and the sequencer waits indefinitely in WAIT_SNT and WAIT_RESP (only `abort` or reset exits).

## Structure
- Package `remote_cmd_seq_pkg` holds:
  - the `seq_state_t` enum;
  - the `seq_err_t` enum (NONE, NAK, TIMEOUT, ABORT);
  - localparams `CMD_CAL`=16'h0000 and `POS_ACK`=8'hA5.
- Sub-module `cmd_fifo`: parameterized DEPTH×16 synchronous FIFO with `push`, `pop`, `flush`, `full`, `empty` and `count`, and registered head output.

## Test plan
- Push 0x0000, 0x2bf1; `start`:
  - `snd_cmd` 2 cycles after `start` with `cmd`=0x0000;
  - after `cmd_snt` and `resp`=A5, `cmd`=0x2bf1 with `snd_cmd` 2 cycles later;
  - after the second ack, `done` pulses and `acked`=2.
- Push 3 commands; second response 0x5A → `err`=1, `err_code`=01, `count`=0, `acked`=1, state IDLE.
- Macro defined, TIMEOUT=100; withhold `resp_rdy` → `err_code`=10 exactly 100 cycles after `snd_cmd`. With the macro undefined, still busy after 10000 cycles.
- Push 9 commands at DEPTH=8 → `count`=8, ninth dropped. Push and pop in the same cycle while full → `count` stays 8.
- `abort` in WAIT_RESP with 2 queued → IDLE next cycle, `err_code`=11, `count`=2. The next `start` clears `err` and resumes at the queued head.
- `start` with an empty FIFO → `done` pulse 1 cycle later, `snd_cmd` never asserts. `rst_n` low mid-WAIT_SNT → all outputs at reset values asynchronously.
